// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and sync-window helpers, shared by the
// sync generator and the RGB pattern generator.
package vga_timing_pkg;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam int CLK_DIV_DEF   = 4;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    localparam int H_TOTAL_DEF      = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF      = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
    localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

    // Half-open window test: lo <= c < hi.
    function automatic logic in_window(input cnt_t c, input cnt_t lo, input cnt_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/pixel_clk_gen.sv
// Pixel-rate enable: a single-clk strobe once every CLK_DIV system clocks.
// No clock is derived; consumers use pclk_tick as a clock enable.
module pixel_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pclk_tick
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] div_count;

    // The strobe is the registered terminal-count decode, so the first tick
    // after reset release lands exactly CLK_DIV clocks later.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_count <= '0;
            pclk_tick <= 1'b0;
        end else begin
            pclk_tick <= (div_count == DIV_LAST);
            if (div_count == DIV_LAST) begin
                div_count <= '0;
            end else begin
                div_count <= div_count + 4'd1;
            end
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters advanced on pclk_tick, with
// registered, mutually aligned sync, display-enable and position outputs.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pclk_tick,
    output logic       h_sync,
    output logic       v_sync,
    output logic       DE,
    output logic [9:0] x_pixel,
    output logic [9:0] y_pixel,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam cnt_t V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam cnt_t H_VIS    = CNT_W'(H_VISIBLE);
    localparam cnt_t V_VIS    = CNT_W'(V_VISIBLE);
    localparam cnt_t HS_START = CNT_W'(H_VISIBLE + H_FP);
    localparam cnt_t HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam cnt_t VS_START = CNT_W'(V_VISIBLE + V_FP);
    localparam cnt_t VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

    cnt_t h_count;
    cnt_t v_count;
    logic origin;
    logic origin_seen;

    pixel_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_clk_gen (
        .clk       (clk),
        .reset     (reset),
        .pclk_tick (pclk_tick)
    );

    assign origin = (h_count == '0) && (v_count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            h_count     <= '0;
            v_count     <= '0;
            x_pixel     <= '0;
            y_pixel     <= '0;
            h_sync      <= 1'b1;
            v_sync      <= 1'b1;
            DE          <= 1'b0;
            frame_start <= 1'b0;
            origin_seen <= 1'b0;
        end else begin
            if (pclk_tick) begin
                if (h_count == H_LAST) begin
                    h_count <= '0;
                    v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
                end else begin
                    h_count <= h_count + 1'b1;
                end
            end

            x_pixel <= h_count;
            y_pixel <= v_count;
            h_sync  <= !in_window(h_count, HS_START, HS_END);
            v_sync  <= !in_window(v_count, VS_START, VS_END);
            DE      <= (h_count < H_VIS) && (v_count < V_VIS);

            // The origin is held for CLK_DIV clocks; only its first clock
            // (after a wrap or reset release) marks the frame start.
            frame_start <= origin && !origin_seen;
            origin_seen <= origin;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen using a reduced raster (15x8) so whole
// frames run quickly; one instance divides by 4, the other by 1.
module tb_vga_sync_gen;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;   // 15
    localparam int VT = VV + VF + VS + VB;   // 8

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       t4, hs4, vs4, de4, fs4;
    logic [9:0] x4, y4;
    logic       t1, hs1, vs1, de1, fs1;
    logic [9:0] x1, y1;

    int errors = 0;
    int checks = 0;

    vga_sync_gen #(
        .CLK_DIV(4), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) u4 (
        .clk(clk), .reset(reset), .pclk_tick(t4), .h_sync(hs4), .v_sync(vs4),
        .DE(de4), .x_pixel(x4), .y_pixel(y4), .frame_start(fs4)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) u1 (
        .clk(clk), .reset(reset), .pclk_tick(t1), .h_sync(hs1), .v_sync(vs1),
        .DE(de1), .x_pixel(x1), .y_pixel(y1), .frame_start(fs1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset4(input string tag);
        chk({tag, " tick"}, 32'(t4), 0);
        chk({tag, " h_sync"}, 32'(hs4), 1);
        chk({tag, " v_sync"}, 32'(vs4), 1);
        chk({tag, " DE"}, 32'(de4), 0);
        chk({tag, " x"}, 32'(x4), 0);
        chk({tag, " y"}, 32'(y4), 0);
        chk({tag, " frame_start"}, 32'(fs4), 0);
        chk({tag, " u1 tick"}, 32'(t1), 0);
    endtask

    // Decode relations between the registered position and the strobes.
    task automatic chk_rel(input string tag, input logic [9:0] x, input logic [9:0] y,
                           input logic hs, input logic vs, input logic de);
        int xi, yi;
        xi = int'(x);
        yi = int'(y);
        chk({tag, " x<HT"}, 32'(xi < HT), 1);
        chk({tag, " y<VT"}, 32'(yi < VT), 1);
        chk({tag, " h_sync"}, 32'(hs), 32'(!(xi >= HV + HF && xi < HV + HF + HS)));
        chk({tag, " v_sync"}, 32'(vs), 32'(!(yi >= VV + VF && yi < VV + VF + VS)));
        chk({tag, " DE"}, 32'(de), 32'(xi < HV && yi < VV));
    endtask

    initial begin
        int n, hl, dl, vl;

        // Reset held for three clocks
        repeat (3) step();
        chk_reset4("reset");

        reset = 1'b0;
        step();
        chk("k1 tick", 32'(t4), 0);
        chk("k1 x", 32'(x4), 0);
        chk("k1 y", 32'(y4), 0);
        chk("k1 DE", 32'(de4), 1);
        chk("k1 frame_start", 32'(fs4), 1);
        chk("k1 h_sync", 32'(hs4), 1);
        chk("k1 u1 tick", 32'(t1), 1);
        chk("k1 u1 frame_start", 32'(fs1), 1);

        // Divider phase and pixel advance from release
        for (int k = 2; k <= 16; k++) begin
            step();
            chk($sformatf("k%0d tick", k), 32'(t4), 32'(k % 4 == 0));
            chk($sformatf("k%0d x", k), 32'(x4), 32'((k - 2) / 4));
            chk($sformatf("k%0d u1 x", k), 32'(x1), 32'(k - 2));
            if (k == 2) chk("k2 frame_start", 32'(fs4), 0);
        end

        // Full-frame measurement, divide-by-4
        n = 0;
        while (fs4 !== 1'b1 && n < 1000) begin step(); n++; end
        chk("u4 wait frame_start", 32'(fs4), 1);
        n = 0; hl = 0; dl = 0; vl = 0;
        do begin
            step();
            n++;
            hl += (hs4 == 1'b0) ? 1 : 0;
            dl += (de4 == 1'b1) ? 1 : 0;
            vl += (vs4 == 1'b0) ? 1 : 0;
            chk_rel("u4", x4, y4, hs4, vs4, de4);
        end while (fs4 !== 1'b1 && n < 1000);
        chk("u4 frame period", 32'(n), 480);
        chk("u4 h_sync low clks", 32'(hl), 96);
        chk("u4 DE high clks", 32'(dl), 128);
        chk("u4 v_sync low clks", 32'(vl), 120);

        // Full-frame measurement, divide-by-1
        n = 0;
        while (fs1 !== 1'b1 && n < 200) begin step(); n++; end
        chk("u1 wait frame_start", 32'(fs1), 1);
        n = 0; hl = 0; dl = 0; vl = 0;
        do begin
            step();
            n++;
            hl += (hs1 == 1'b0) ? 1 : 0;
            dl += (de1 == 1'b1) ? 1 : 0;
            vl += (vs1 == 1'b0) ? 1 : 0;
            chk("u1 tick const", 32'(t1), 1);
            chk_rel("u1", x1, y1, hs1, vs1, de1);
        end while (fs1 !== 1'b1 && n < 200);
        chk("u1 frame period", 32'(n), 120);
        chk("u1 h_sync low clks", 32'(hl), 24);
        chk("u1 DE high clks", 32'(dl), 32);
        chk("u1 v_sync low clks", 32'(vl), 30);

        // Simultaneous line and frame wrap
        n = 0;
        while (!(x4 == 10'(HT - 1) && y4 == 10'(VT - 1)) && n < 600) begin step(); n++; end
        chk("wait last pixel", 32'(x4 == 10'(HT - 1) && y4 == 10'(VT - 1)), 1);
        n = 0;
        while (x4 == 10'(HT - 1) && n < 10) begin step(); n++; end
        chk("wrap x", 32'(x4), 0);
        chk("wrap y", 32'(y4), 0);
        chk("wrap DE", 32'(de4), 1);
        chk("wrap frame_start", 32'(fs4), 1);
        step();
        chk("wrap+1 frame_start", 32'(fs4), 0);
        chk("wrap+1 x", 32'(x4), 0);

        // Reset mid-frame, mid divider phase
        n = 0;
        while (!(x4 == 10'd5 && y4 == 10'd2) && n < 600) begin step(); n++; end
        chk("wait x5 y2", 32'(x4 == 10'd5 && y4 == 10'd2), 1);
        step();
        reset = 1'b1;
        step();
        chk_reset4("midreset");
        reset = 1'b0;
        step();
        chk("resume x", 32'(x4), 0);
        chk("resume y", 32'(y4), 0);
        chk("resume DE", 32'(de4), 1);
        chk("resume frame_start", 32'(fs4), 1);
        chk("resume tick k1", 32'(t4), 0);
        step();
        step();
        chk("resume tick k3", 32'(t4), 0);
        step();
        chk("resume tick k4", 32'(t4), 1);
        step();
        step();
        chk("resume x k6", 32'(x4), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
